// File: rtl/jstk_spi_master_pkg.sv
// rtl/jstk_spi_master_pkg.sv - shared constants, FSM states and counter sizing for the JSTK2 SPI poller
package jstk_spi_master_pkg;

  localparam logic [9:0] JSTK_NEUTRAL = 10'd512;
  localparam int         JSTK_NBYTES  = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_WAIT  = 3'd5
  } state_e;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jstk_spi_master_byte_shifter.sv
// rtl/jstk_spi_master_byte_shifter.sv - 8-bit SPI mode-0 MSB-first shift register
module jstk_spi_master_byte_shifter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       shift_out_en,
  input  logic       sample_en,
  input  logic       miso,
  output logic       mosi,
  output logic [7:0] byte_out
);

  logic [7:0] tx_q;
  logic [7:0] tx_d;
  logic [7:0] rx_q;
  logic [7:0] rx_d;

  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load) begin
      tx_d = byte_in;
    end else if (shift_out_en) begin
      tx_d = {tx_q[6:0], 1'b0};
    end
    if (sample_en) begin
      rx_d = {rx_q[6:0], miso};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_q <= 8'h00;
      rx_q <= 8'h00;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign mosi     = tx_q[7];
  assign byte_out = rx_q;

endmodule

// File: rtl/jstk_spi_master.sv
// rtl/jstk_spi_master.sv - Pmod JSTK2 poller: 5-byte SPI mode-0 transaction per poll period
module jstk_spi_master
  import jstk_spi_master_pkg::*;
#(
  parameter int         SCLK_HALF_CYC   = 50,
  parameter int         SS_SETUP_CYC    = 750,
  parameter int         BYTE_GAP_CYC    = 500,
  parameter int         SS_HOLD_CYC     = 1250,
  parameter int         POLL_PERIOD_CYC = 500000,
  parameter logic [7:0] CMD_BYTE        = 8'h00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_ss_n,
  output logic [9:0] jstk_x,
  output logic [9:0] jstk_y,
  output logic       btn_jstk,
  output logic       btn_trig,
  output logic       sample_valid,
  output logic       busy
);

  localparam int HW  = cnt_width(SCLK_HALF_CYC);
  localparam int PW  = cnt_width(max3(SS_SETUP_CYC, BYTE_GAP_CYC, SS_HOLD_CYC));
  localparam int PLW = cnt_width(POLL_PERIOD_CYC);

  localparam logic [HW-1:0]  HALF_LAST  = HW'(SCLK_HALF_CYC - 1);
  localparam logic [PW-1:0]  SETUP_LAST = PW'(SS_SETUP_CYC - 1);
  localparam logic [PW-1:0]  GAP_LAST   = PW'(BYTE_GAP_CYC - 1);
  localparam logic [PW-1:0]  HOLD_LAST  = PW'(SS_HOLD_CYC - 1);
  localparam logic [PLW-1:0] POLL_LAST  = PLW'(POLL_PERIOD_CYC - 1);
  localparam logic [PLW-1:0] POLL_EXIT  = PLW'(POLL_PERIOD_CYC - 2);
  localparam logic [2:0]     LAST_BYTE  = 3'(JSTK_NBYTES - 1);

  state_e         state_q, state_d;
  logic [PW-1:0]  ph_q, ph_d;
  logic [HW-1:0]  hc_q, hc_d;
  logic [PLW-1:0] poll_q, poll_d;
  logic [2:0]     bit_q, bit_d;
  logic [2:0]     byte_q, byte_d;
  logic           sclk_q, sclk_d;
  logic           ss_n_q, ss_n_d;
  logic           busy_q, busy_d;
  logic           sv_q, sv_d;
  logic [7:0]     x_lo_q, x_lo_d, y_lo_q, y_lo_d;
  logic [1:0]     x_hi_q, x_hi_d, y_hi_q, y_hi_d, btn_q, btn_d;
  logic [9:0]     jx_q, jx_d, jy_q, jy_d;
  logic           bj_q, bj_d, bt_q, bt_d;
  logic           miso_s1_q, miso_s2_q;

  logic           sh_load, sh_shift, sh_sample;
  logic [7:0]     sh_byte_in, sh_byte_out;

  jstk_spi_master_byte_shifter u_shifter (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (sh_load),
    .byte_in      (sh_byte_in),
    .shift_out_en (sh_shift),
    .sample_en    (sh_sample),
    .miso         (miso_s2_q),
    .mosi         (spi_mosi),
    .byte_out     (sh_byte_out)
  );

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    hc_d       = hc_q;
    poll_d     = (poll_q == POLL_LAST) ? poll_q : poll_q + 1'b1;
    bit_d      = bit_q;
    byte_d     = byte_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    sv_d       = 1'b0;
    x_lo_d     = x_lo_q;
    x_hi_d     = x_hi_q;
    y_lo_d     = y_lo_q;
    y_hi_d     = y_hi_q;
    btn_d      = btn_q;
    jx_d       = jx_q;
    jy_d       = jy_q;
    bj_d       = bj_q;
    bt_d       = bt_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_sample  = 1'b0;
    sh_byte_in = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          poll_d  = '0;
          ph_d    = '0;
          byte_d  = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (ph_q == SETUP_LAST) begin
          sh_load    = 1'b1;
          sh_byte_in = CMD_BYTE;
          hc_d       = '0;
          bit_d      = '0;
          state_d    = ST_SHIFT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (hc_q != HALF_LAST) begin
          hc_d = hc_q + 1'b1;
        end else begin
          hc_d   = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            sh_sample = 1'b1;
          end else begin
            sh_shift = 1'b1;
            bit_d    = bit_q + 1'b1;
            // Eighth falling edge: the received byte is complete, file it away.
            if (bit_q == 3'd7) begin
              case (byte_q)
                3'd0:    x_lo_d = sh_byte_out;
                3'd1:    x_hi_d = sh_byte_out[1:0];
                3'd2:    y_lo_d = sh_byte_out;
                3'd3:    y_hi_d = sh_byte_out[1:0];
                default: btn_d  = sh_byte_out[1:0];
              endcase
              ph_d    = '0;
              state_d = (byte_q == LAST_BYTE) ? ST_HOLD : ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (ph_q == GAP_LAST) begin
          sh_load    = 1'b1;
          sh_byte_in = 8'h00;
          byte_d     = byte_q + 1'b1;
          hc_d       = '0;
          bit_d      = '0;
          state_d    = ST_SHIFT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (ph_q == HOLD_LAST) begin
          ss_n_d  = 1'b1;
          busy_d  = 1'b0;
          sv_d    = 1'b1;
          jx_d    = {x_hi_q, x_lo_q};
          jy_d    = {y_hi_q, y_lo_q};
          bj_d    = btn_q[0];
          bt_d    = btn_q[1];
          state_d = ST_WAIT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // Leave when the counter is about to reach POLL-1 so the IDLE launch lands exactly one period on.
        if (poll_q >= POLL_EXIT) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      hc_q      <= '0;
      poll_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      sclk_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      sv_q      <= 1'b0;
      x_lo_q    <= 8'h00;
      x_hi_q    <= 2'b00;
      y_lo_q    <= 8'h00;
      y_hi_q    <= 2'b00;
      btn_q     <= 2'b00;
      jx_q      <= JSTK_NEUTRAL;
      jy_q      <= JSTK_NEUTRAL;
      bj_q      <= 1'b0;
      bt_q      <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      hc_q      <= hc_d;
      poll_q    <= poll_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sclk_q    <= sclk_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      sv_q      <= sv_d;
      x_lo_q    <= x_lo_d;
      x_hi_q    <= x_hi_d;
      y_lo_q    <= y_lo_d;
      y_hi_q    <= y_hi_d;
      btn_q     <= btn_d;
      jx_q      <= jx_d;
      jy_q      <= jy_d;
      bj_q      <= bj_d;
      bt_q      <= bt_d;
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  assign spi_sclk     = sclk_q;
  assign spi_ss_n     = ss_n_q;
  assign busy         = busy_q;
  assign sample_valid = sv_q;
  assign jstk_x       = jx_q;
  assign jstk_y       = jy_q;
  assign btn_jstk     = bj_q;
  assign btn_trig     = bt_q;

endmodule
